xmr_inject_sink: RTL and testbench

- Downward (writer-side) counterpart of the XMR export path. The XMR pass already turns a hierarchical read of a sub-module signal into an `__xmr__` output port.
- This block covers the opposite case: a parent-level hierarchical write/force of a sub-module register, converted to ported signals.
- Instantiated inside the target sub-module, it owns the target register. It arbitrates between the functional next-state logic and injected values arriving on `__xmr__` input ports, using a valid/ready handshake and a bounded or open-ended force window.

---
 rtl/xmr_inject_sink.sv | 144 ++++++++++++++
 tb/tb_xmr_inject_sink.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/xmr_inject_sink.sv
// rtl/xmr_inject_sink.sv - target register owner arbitrating functional writes against ported hierarchical injections
//
// Purpose:
//   Owns a sub-module register and replaces a parent-level hierarchical
//   write/force with ported signals. The functional path writes q through
//   func_en/func_d. The parent forces q through a valid/ready handshake on
//   the inj_* ports. A force lasts either a fixed number of cycles
//   (inj_hold != 0) or until inj_release (inj_hold == 0).
//
// Ports:
//   clk          design clock
//   rst_n        asynchronous active-low reset
//   func_en      functional write enable
//   func_d       functional next value              [WIDTH]
//   inj_valid    injection request
//   inj_ready    injection can be accepted (state == IDLE)
//   inj_data     value to force                     [WIDTH]
//   inj_hold     force length in cycles, 0 = open   [HOLD_W]
//   inj_release  ends an active force on this edge
//   q            resolved register value            [WIDTH]
//   forced       high while a force is in effect
//   done         one-cycle pulse after a force ends

module xmr_inject_sink #(
    parameter int unsigned          WIDTH     = 1,
    parameter int unsigned          HOLD_W    = 8,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0,
    parameter bit                   SHADOW    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              func_en,
    input  logic [WIDTH-1:0]  func_d,
    input  logic              inj_valid,
    output logic              inj_ready,
    input  logic [WIDTH-1:0]  inj_data,
    input  logic [HOLD_W-1:0] inj_hold,
    input  logic              inj_release,
    output logic [WIDTH-1:0]  q,
    output logic              forced,
    output logic              done
);

    typedef enum logic {
        IDLE  = 1'b0,
        FORCE = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [HOLD_W-1:0] cnt;
    logic [HOLD_W-1:0] cnt_nxt;
    logic [WIDTH-1:0]  shadow;
    logic [WIDTH-1:0]  shadow_nxt;
    logic [WIDTH-1:0]  q_nxt;
    logic              forced_nxt;
    logic              done_nxt;

    logic accept;
    logic exit_force;

    assign inj_ready  = (state == IDLE);
    assign accept     = inj_valid && inj_ready;
    // cnt == 0 marks an open-ended force; it only ever leaves via release.
    assign exit_force = (state == FORCE) &&
                        (inj_release || (cnt == HOLD_W'(1)));

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            shadow <= RESET_VAL;
            q      <= RESET_VAL;
            forced <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            shadow <= shadow_nxt;
            q      <= q_nxt;
            forced <= forced_nxt;
            done   <= done_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)     state_nxt = FORCE;
            FORCE:   if (exit_force) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        q_nxt      = q;
        shadow_nxt = shadow;
        cnt_nxt    = cnt;
        forced_nxt = forced;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    // Injection wins q, but the functional value of this
                    // cycle is parked in the shadow so it is not lost.
                    q_nxt      = inj_data;
                    shadow_nxt = func_en ? func_d : q;
                    cnt_nxt    = inj_hold;
                    forced_nxt = 1'b1;
                end else if (func_en) begin
                    q_nxt = func_d;
                    if (SHADOW) begin
                        shadow_nxt = func_d;
                    end
                end
            end
            FORCE: begin
                if (SHADOW && func_en) begin
                    shadow_nxt = func_d;
                end
                if (exit_force) begin
                    forced_nxt = 1'b0;
                    done_nxt   = 1'b1;
                    cnt_nxt    = '0;
                    // Functional write on the exit edge beats the shadow.
                    if (func_en) begin
                        q_nxt = func_d;
                    end else if (SHADOW) begin
                        q_nxt = shadow;
                    end
                end else if (cnt > HOLD_W'(1)) begin
                    cnt_nxt = cnt - HOLD_W'(1);
                end
            end
            default: begin
                forced_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_xmr_inject_sink.sv
// tb/tb_xmr_inject_sink.sv - directed scoreboard bench for xmr_inject_sink

module tb_xmr_inject_sink;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       func_en;
    logic [7:0] func_d;
    logic       inj_valid;
    logic [7:0] inj_data;
    logic [7:0] inj_hold;
    logic       inj_release;

    logic       rdy_s1, forced_s1, done_s1;
    logic [7:0] q_s1;
    logic       rdy_s0, forced_s0, done_s0;
    logic [7:0] q_s0;
    logic       rdy_w1, forced_w1, done_w1;
    logic [0:0] q_w1;

    always #5 clk = ~clk;

    xmr_inject_sink #(.WIDTH(8), .HOLD_W(8), .RESET_VAL(8'h00), .SHADOW(1'b1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .func_en(func_en), .func_d(func_d),
        .inj_valid(inj_valid), .inj_ready(rdy_s1), .inj_data(inj_data),
        .inj_hold(inj_hold), .inj_release(inj_release),
        .q(q_s1), .forced(forced_s1), .done(done_s1)
    );

    xmr_inject_sink #(.WIDTH(8), .HOLD_W(8), .RESET_VAL(8'h00), .SHADOW(1'b0)) dut_s0 (
        .clk(clk), .rst_n(rst_n), .func_en(func_en), .func_d(func_d),
        .inj_valid(inj_valid), .inj_ready(rdy_s0), .inj_data(inj_data),
        .inj_hold(inj_hold), .inj_release(inj_release),
        .q(q_s0), .forced(forced_s0), .done(done_s0)
    );

    xmr_inject_sink #(.WIDTH(1), .HOLD_W(8), .RESET_VAL(1'b0), .SHADOW(1'b1)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .func_en(func_en), .func_d(func_d[0:0]),
        .inj_valid(inj_valid), .inj_ready(rdy_w1), .inj_data(inj_data[0:0]),
        .inj_hold(inj_hold), .inj_release(inj_release),
        .q(q_w1), .forced(forced_w1), .done(done_w1)
    );

    typedef struct {
        string      tag;
        int         sel;
        logic [10:0] vec;   // {q, forced, done, inj_ready}
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    function automatic logic [10:0] observe(input int sel);
        case (sel)
            0:       return {q_s1, forced_s1, done_s1, rdy_s1};
            1:       return {q_s0, forced_s0, done_s0, rdy_s0};
            default: return {7'd0, q_w1, forced_w1, done_w1, rdy_w1};
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [7:0] eq,
                        input logic ef, input logic ed, input logic er);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.vec = {eq, ef, ed, er};
        exp_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t        e;
        logic [10:0] obs;
        e   = exp_q.pop_front();
        obs = observe(e.sel);
        total_cnt++;
        assert (obs === e.vec) pass_cnt++;
        else $error("FAIL %s dut%0d: q/forced/done/ready observed %h/%b/%b/%b expected %h/%b/%b/%b",
                    e.tag, e.sel, obs[10:3], obs[2], obs[1], obs[0],
                    e.vec[10:3], e.vec[2], e.vec[1], e.vec[0]);
    endtask

    // Check now, without a clock edge.
    task automatic chk(input string tag, input int sel, input logic [7:0] eq,
                       input logic ef, input logic ed, input logic er);
        push(tag, sel, eq, ef, ed, er);
        pop_check();
    endtask

    // Expectation is queued with the stimulus, compared after the edge.
    task automatic step(input string tag, input int sel, input logic [7:0] eq,
                        input logic ef, input logic ed, input logic er);
        push(tag, sel, eq, ef, ed, er);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        rst_n       = 1'b0;
        func_en     = 1'b0;
        func_d      = 8'h00;
        inj_valid   = 1'b0;
        inj_data    = 8'h00;
        inj_hold    = 8'h00;
        inj_release = 1'b0;
        #2;
        chk("reset_s1", 0, 8'h00, 0, 0, 1);
        chk("reset_s0", 1, 8'h00, 0, 0, 1);
        chk("reset_w1", 2, 8'h00, 0, 0, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // WIDTH=1 functional write
        func_en = 1'b1; func_d = 8'h01;
        step("w1_func", 2, 8'h01, 0, 0, 1);

        // Timed force with shadow tracking
        func_d = 8'h10;
        step("set10", 0, 8'h10, 0, 0, 1);
        func_en = 1'b0;
        inj_valid = 1'b1; inj_data = 8'hAA; inj_hold = 8'd3;
        step("t_acc", 0, 8'hAA, 1, 0, 0);
        inj_valid = 1'b0;
        func_en = 1'b1; func_d = 8'h55;
        step("t_f1", 0, 8'hAA, 1, 0, 0);
        func_en = 1'b0;
        step("t_f2", 0, 8'hAA, 1, 0, 0);
        step("t_exit", 0, 8'h55, 0, 1, 1);
        step("t_post", 0, 8'h55, 0, 0, 1);

        // Open-ended force with a second request held during it
        inj_valid = 1'b1; inj_data = 8'h0F; inj_hold = 8'd0;
        step("o_acc", 0, 8'h0F, 1, 0, 0);
        inj_data = 8'h3C; inj_hold = 8'd2;
        for (int i = 0; i < 19; i++) begin
            step("o_hold", 0, 8'h0F, 1, 0, 0);
        end
        inj_release = 1'b1;
        step("o_exit", 0, 8'h55, 0, 1, 1);
        inj_release = 1'b0;
        step("o_acc2", 0, 8'h3C, 1, 0, 0);
        inj_valid = 1'b0;
        step("o2_hold", 0, 8'h3C, 1, 0, 0);
        step("o2_exit", 0, 8'h55, 0, 1, 1);
        step("o2_post", 0, 8'h55, 0, 0, 1);

        // SHADOW=0: forced value persists after release
        func_en = 1'b1; func_d = 8'h10;
        step("s0_set", 1, 8'h10, 0, 0, 1);
        func_en = 1'b0;
        inj_valid = 1'b1; inj_data = 8'hAA; inj_hold = 8'd2;
        step("s0_acc", 1, 8'hAA, 1, 0, 0);
        inj_valid = 1'b0;
        step("s0_hold", 1, 8'hAA, 1, 0, 0);
        step("s0_exit", 1, 8'hAA, 0, 1, 1);
        step("s0_keep1", 1, 8'hAA, 0, 0, 1);
        step("s0_keep2", 1, 8'hAA, 0, 0, 1);
        func_en = 1'b1; func_d = 8'h33;
        step("s0_func", 1, 8'h33, 0, 0, 1);
        func_en = 1'b0;

        // Release and cnt==1 coincide with a functional write
        inj_valid = 1'b1; inj_data = 8'hAA; inj_hold = 8'd2;
        step("sim_acc", 0, 8'hAA, 1, 0, 0);
        inj_valid = 1'b0;
        step("sim_hold", 0, 8'hAA, 1, 0, 0);
        func_en = 1'b1; func_d = 8'h77; inj_release = 1'b1;
        step("sim_exit", 0, 8'h77, 0, 1, 1);
        func_en = 1'b0; inj_release = 1'b0;
        step("sim_post1", 0, 8'h77, 0, 0, 1);
        step("sim_post2", 0, 8'h77, 0, 0, 1);

        // Reset in the middle of a long force
        inj_valid = 1'b1; inj_data = 8'hAA; inj_hold = 8'd100;
        step("rf_acc", 0, 8'hAA, 1, 0, 0);
        inj_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step("rf_hold", 0, 8'hAA, 1, 0, 0);
        end
        rst_n = 1'b0;
        #1;
        chk("rf_async", 0, 8'h00, 0, 0, 1);
        step("rf_inrst", 0, 8'h00, 0, 0, 1);
        rst_n = 1'b1;
        step("rf_idle", 0, 8'h00, 0, 0, 1);
        inj_valid = 1'b1; inj_data = 8'h5A; inj_hold = 8'd1;
        step("rf_acc2", 0, 8'h5A, 1, 0, 0);
        inj_valid = 1'b0;
        step("rf_exit2", 0, 8'h00, 0, 1, 1);
        step("rf_post2", 0, 8'h00, 0, 0, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
